// File: rtl/ram_dp_pkg.sv
// Shared definitions for the parametrised dual-port RAM family.
// Provides the read-during-write mode codes, the write-priority codes and
// a helper that turns an address width into a memory depth.
package ram_dp_pkg;

    localparam int unsigned RDW_OLD = 0;  // read-first: return pre-write contents
    localparam int unsigned RDW_NEW = 1;  // write-first: return the stored write data
    localparam int unsigned PRIO_A  = 0;  // port A wins a same-address write
    localparam int unsigned PRIO_B  = 1;  // port B wins a same-address write

    function automatic int unsigned depth_f(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/ram_dp_coll_mon.sv
// Write-write collision monitor for ram_dp_param.
// A collision is both ports writing the same address in the same cycle.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   en_*_i, we_*_i       per-port enable / write enable
//   addr_*_i             per-port address
//   coll_pulse_o         combinational collision indication for this cycle
//   coll_o               sticky collision flag, cleared only by reset
//   coll_cnt_o           saturating collision count
module ram_dp_coll_mon
    import ram_dp_pkg::*;
#(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_a_i,
    input  logic              we_a_i,
    input  logic [ADDR_W-1:0] addr_a_i,
    input  logic              en_b_i,
    input  logic              we_b_i,
    input  logic [ADDR_W-1:0] addr_b_i,
    output logic              coll_pulse_o,
    output logic              coll_o,
    output logic [CNT_W-1:0]  coll_cnt_o
);

    logic             coll_q, coll_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        coll_pulse_o = en_a_i & we_a_i & en_b_i & we_b_i & (addr_a_i == addr_b_i);
        coll_d       = coll_q | coll_pulse_o;
        cnt_d        = cnt_q;
        // Hold at all-ones instead of wrapping back to zero.
        if (coll_pulse_o && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coll_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            coll_q <= coll_d;
            cnt_q  <= cnt_d;
        end
    end

    assign coll_o     = coll_q;
    assign coll_cnt_o = cnt_q;

endmodule

// File: rtl/ram_dp_param.sv
// Parametrised true dual-port synchronous RAM, single clock domain.
// Two independent ports each read or write one word per cycle; read data
// is registered. Read-during-write behaviour (same port and cross port) is
// selected by RDW_MODE, same-address write arbitration by WR_PRIO.
// Optional build macro RAM_DP_OUT_REG_EN adds a second output register
// stage on dout/vld (read latency 2 instead of 1).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   en_x, we_x, addr_x, din_x  port x access enable, write enable, address, data
//   dout_x, vld_x              port x registered read data and valid strobe
//   coll, coll_cnt             sticky collision flag, saturating collision count
module ram_dp_param
    import ram_dp_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned RDW_MODE = 0,
    parameter int unsigned WR_PRIO  = 0,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] dout_a,
    output logic              vld_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_b,
    output logic              vld_b,
    output logic              coll,
    output logic [CNT_W-1:0]  coll_cnt
);

    localparam int unsigned DEPTH = depth_f(ADDR_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] dout_a_q, dout_b_q, rd_a_d, rd_b_d;
    logic              vld_a_q, vld_b_q;
    logic              coll_pulse, keep_a, keep_b;

    ram_dp_coll_mon #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_coll_mon (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_a_i       (en_a),
        .we_a_i       (we_a),
        .addr_a_i     (addr_a),
        .en_b_i       (en_b),
        .we_b_i       (we_b),
        .addr_b_i     (addr_b),
        .coll_pulse_o (coll_pulse),
        .coll_o       (coll),
        .coll_cnt_o   (coll_cnt)
    );

    // A write is committed only outside reset, and on a collision only the
    // priority port commits, so keep_a and keep_b never target one address.
    always_comb begin
        keep_a = rst_n & en_a & we_a & ~(coll_pulse & (WR_PRIO == PRIO_B));
        keep_b = rst_n & en_b & we_b & ~(coll_pulse & (WR_PRIO == PRIO_A));
    end

    // Write-first returns whatever the location will hold after this edge,
    // which covers own-port, forwarded and arbitrated-collision cases alike.
    always_comb begin
        rd_a_d = mem_q[addr_a];
        rd_b_d = mem_q[addr_b];
        if (RDW_MODE == RDW_NEW) begin
            if (keep_a) begin
                rd_a_d = din_a;
            end else if (keep_b && (addr_b == addr_a)) begin
                rd_a_d = din_b;
            end
            if (keep_b) begin
                rd_b_d = din_b;
            end else if (keep_a && (addr_a == addr_b)) begin
                rd_b_d = din_a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (keep_a) begin
            mem_q[addr_a] <= din_a;
        end
        if (keep_b) begin
            mem_q[addr_b] <= din_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_a_q <= '0;
            dout_b_q <= '0;
            vld_a_q  <= 1'b0;
            vld_b_q  <= 1'b0;
        end else begin
            vld_a_q <= en_a;
            vld_b_q <= en_b;
            if (en_a) begin
                dout_a_q <= rd_a_d;
            end
            if (en_b) begin
                dout_b_q <= rd_b_d;
            end
        end
    end

`ifdef RAM_DP_OUT_REG_EN
    logic [DATA_W-1:0] dout_a_q2, dout_b_q2;
    logic              vld_a_q2, vld_b_q2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_a_q2 <= '0;
            dout_b_q2 <= '0;
            vld_a_q2  <= 1'b0;
            vld_b_q2  <= 1'b0;
        end else begin
            dout_a_q2 <= dout_a_q;
            dout_b_q2 <= dout_b_q;
            vld_a_q2  <= vld_a_q;
            vld_b_q2  <= vld_b_q;
        end
    end

    assign dout_a = dout_a_q2;
    assign dout_b = dout_b_q2;
    assign vld_a  = vld_a_q2;
    assign vld_b  = vld_b_q2;
`else
    assign dout_a = dout_a_q;
    assign dout_b = dout_b_q;
    assign vld_a  = vld_a_q;
    assign vld_b  = vld_b_q;
`endif

endmodule

// File: tb/tb_ram_dp_param.sv
// Self-checking bench for ram_dp_param. Two instances share the stimulus:
// cfg 0 = read-first, port A priority, 8-bit counter;
// cfg 1 = write-first, port B priority, 2-bit counter.
module tb_ram_dp_param;

    localparam int DW = 8;
    localparam int AW = 6;
`ifdef RAM_DP_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, en_a, we_a, en_b, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] din_a, din_b;
    logic [DW-1:0] dout_a0, dout_b0, dout_a1, dout_b1;
    logic          vld_a0, vld_b0, vld_a1, vld_b1, coll0, coll1;
    logic [7:0]    cnt0;
    logic [1:0]    cnt1;

    ram_dp_param #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0), .WR_PRIO(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a0), .vld_a(vld_a0),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b0), .vld_b(vld_b0),
        .coll(coll0), .coll_cnt(cnt0));

    ram_dp_param #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1), .WR_PRIO(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a1), .vld_a(vld_a1),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b1), .vld_b(vld_b1),
        .coll(coll1), .coll_cnt(cnt1));

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: plain memory arrays; X marks never-written words.
    int            rdw  [2] = '{0, 1};
    int            prio [2] = '{0, 1};
    int            cmax [2] = '{255, 3};
    logic [DW-1:0] mmem [2][64];
    logic [DW-1:0] s1d  [2][2];
    logic [DW-1:0] s2d  [2][2];
    bit            s1v  [2][2];
    bit            s2v  [2][2];
    bit            mcoll[2];
    int            mcnt [2];

    task automatic model_edge();
        bit            en [2];
        bit            wr [2];
        logic [AW-1:0] ad [2];
        logic [DW-1:0] dn [2];
        logic [DW-1:0] oldv [2];
        bit            clsn;
        en[0] = en_a; en[1] = en_b;
        wr[0] = en_a && we_a; wr[1] = en_b && we_b;
        ad[0] = addr_a; ad[1] = addr_b;
        dn[0] = din_a; dn[1] = din_b;
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < 2; p++) begin
                s2d[c][p] = rst_n ? s1d[c][p] : '0;
                s2v[c][p] = rst_n ? s1v[c][p] : 1'b0;
            end
            if (!rst_n) begin
                for (int p = 0; p < 2; p++) begin
                    s1d[c][p] = '0;
                    s1v[c][p] = 1'b0;
                end
                mcoll[c] = 1'b0;
                mcnt[c]  = 0;
                continue;
            end
            clsn = wr[0] && wr[1] && (ad[0] == ad[1]);
            for (int p = 0; p < 2; p++) oldv[p] = mmem[c][ad[p]];
            if (clsn) begin
                mmem[c][ad[0]] = (prio[c] == 1) ? dn[1] : dn[0];
            end else begin
                for (int p = 0; p < 2; p++) if (wr[p]) mmem[c][ad[p]] = dn[p];
            end
            for (int p = 0; p < 2; p++) begin
                s1v[c][p] = en[p];
                if (en[p]) s1d[c][p] = (rdw[c] == 1) ? mmem[c][ad[p]] : oldv[p];
            end
            if (clsn) begin
                mcoll[c] = 1'b1;
                if (mcnt[c] < cmax[c]) mcnt[c]++;
            end
        end
    endtask

    task automatic check_dout(input string tag, input logic [DW-1:0] obs, input int c, input int p);
        logic [DW-1:0] e;
        e = (LAT == 2) ? s2d[c][p] : s1d[c][p];
        if (!$isunknown(e)) check_eq(tag, {24'd0, obs}, {24'd0, e});
    endtask

    task automatic check_all();
        check_dout("dout_a0", dout_a0, 0, 0);
        check_dout("dout_b0", dout_b0, 0, 1);
        check_dout("dout_a1", dout_a1, 1, 0);
        check_dout("dout_b1", dout_b1, 1, 1);
        check_eq("vld_a0", vld_a0, (LAT == 2) ? s2v[0][0] : s1v[0][0]);
        check_eq("vld_b0", vld_b0, (LAT == 2) ? s2v[0][1] : s1v[0][1]);
        check_eq("vld_a1", vld_a1, (LAT == 2) ? s2v[1][0] : s1v[1][0]);
        check_eq("vld_b1", vld_b1, (LAT == 2) ? s2v[1][1] : s1v[1][1]);
        check_eq("coll0", coll0, mcoll[0]);
        check_eq("coll1", coll1, mcoll[1]);
        check_eq("coll_cnt0", cnt0, mcnt[0]);
        check_eq("coll_cnt1", cnt1, mcnt[1]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        en_a = 0; we_a = 0; en_b = 0; we_b = 0;
    endtask

    task automatic drive_a(input bit en, input bit we, input int ad, input int d);
        en_a = en; we_a = we; addr_a = AW'(ad); din_a = DW'(d);
    endtask

    task automatic drive_b(input bit en, input bit we, input int ad, input int d);
        en_b = en; we_b = we; addr_b = AW'(ad); din_b = DW'(d);
    endtask

    // Lets the optional second output stage catch up before a direct check.
    task automatic settle();
        if (LAT == 2) begin
            idle();
            step();
        end
    endtask

    initial begin
        for (int c = 0; c < 2; c++) for (int p = 0; p < 2; p++) begin
            s1d[c][p] = '0; s2d[c][p] = '0; s1v[c][p] = 0; s2v[c][p] = 0;
        end
        rst_n = 0; idle(); addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
        step(); step();
        check_eq("rst_coll0", coll0, 0);
        check_eq("rst_vld_b1", vld_b1, 0);
        rst_n = 1;

        // Fill every location so later reads are fully predictable.
        for (int i = 0; i < 64; i++) begin
            drive_a(1, 1, i, $urandom_range(0, 255));
            drive_b(0, 0, 0, 0);
            step();
        end

        // Write then read back on the other port.
        idle(); drive_a(1, 1, 3, 8'hA5); step();
        idle(); drive_b(1, 0, 3, 0); step();
        settle();
        check_eq("tp1_dout_b0", dout_b0, 8'hA5);
        check_eq("tp1_dout_b1", dout_b1, 8'hA5);
        check_eq("tp1_coll0", coll0, 0);

        // Cross-port read during write.
        idle(); drive_a(1, 1, 7, 8'h11); step();
        drive_a(1, 1, 7, 8'h22); drive_b(1, 0, 7, 0); step();
        settle();
        check_eq("rdw_old_b0", dout_b0, 8'h11);
        check_eq("rdw_new_b1", dout_b1, 8'h22);
        idle(); drive_b(1, 0, 7, 0); step();
        settle();
        check_eq("rdw_after_b0", dout_b0, 8'h22);

        // Same-address write-write collision at the top address.
        idle(); drive_a(1, 1, 63, 8'h33); drive_b(1, 1, 63, 8'h44); step();
        check_eq("coll_cnt0_1", cnt0, 1);
        check_eq("coll1_set", coll1, 1);
        idle(); drive_a(1, 0, 63, 0); step();
        settle();
        check_eq("prio_a_rd", dout_a0, 8'h33);
        check_eq("prio_b_rd", dout_a1, 8'h44);

        // Counter saturation on the 2-bit instance.
        for (int k = 2; k <= 5; k++) begin
            drive_a(1, 1, 10, k); drive_b(1, 1, 10, k + 16); step();
            check_eq("sat_cnt1", cnt1, (k > 3) ? 3 : k);
            check_eq("sat_cnt0", cnt0, k);
        end

        // Reset in the same cycle as a pending read.
        idle(); drive_b(1, 0, 3, 0); rst_n = 0; step();
        check_eq("rst_vld_b0", vld_b0, 0);
        check_eq("rst_dout_b0", dout_b0, 0);
        check_eq("rst_coll_cnt1", cnt1, 0);
        rst_n = 1; idle(); drive_b(1, 0, 3, 0); step();
        settle();
        check_eq("retain_b0", dout_b0, 8'hA5);

        // Random traffic over a narrow address window to provoke collisions.
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            drive_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 4) == 0) ? 63 : $urandom_range(0, 3), $urandom_range(0, 255));
            drive_b($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 4) == 0) ? 63 : $urandom_range(0, 3), $urandom_range(0, 255));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
